peripheral_interrupt_arbiter: RTL and testbench

Parametrised next-generation peripheral interrupt collector sitting between the peripheral interrupt lines and the CSR unit's external-interrupt input. Detects rising edges on enabled peripheral requests and the memory-error line, holds them as sticky pending bits so no event is lost when the queue is full, and arbitrates them into a configurable-depth cause FIFO. It presents one cause at a time to the CSR unit over the `p_int`/`p_int_read` handshake.

---
 rtl/periph_int_pkg.sv | 14 +
 rtl/peripheral_int_fifo.sv | 62 ++++++
 rtl/peripheral_interrupt_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_peripheral_interrupt_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_int_pkg.sv
// Shared types and default cause numbering for the peripheral interrupt arbiter.
package periph_int_pkg;

  // Output handshake states toward the CSR unit.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Default mcause numbering: memory error, then peripheral sources upward.
  localparam logic [31:0] DEF_MEM_ERR_CAUSE = 32'd12;
  localparam logic [31:0] DEF_CAUSE_BASE    = 32'd13;

endpackage

// File: rtl/peripheral_int_fifo.sv
// Circular cause buffer with explicit pointer wrap, so any depth >= 2 works.
module peripheral_int_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count < CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign o_head    = r_mem[r_head];
  assign o_count   = r_count;

  // Storage write; contents are cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // Head/tail pointers wrap at DEPTH explicitly; count nets push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
      end
      if (w_do_pop) begin
        r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_interrupt_arbiter.sv
// Edge-detecting interrupt collector: sticky pending bits, one-per-cycle
// arbitration into a cause FIFO, and a two-state handshake to the CSR unit.
module peripheral_interrupt_arbiter
  import periph_int_pkg::*;
#(
  parameter int unsigned NUM_INTER     = 52,
  parameter int unsigned QUEUE_DEPTH   = 8,
  parameter int unsigned ARB_MODE      = 0,
  parameter logic [31:0] MEM_ERR_CAUSE = DEF_MEM_ERR_CAUSE,
  parameter logic [31:0] CAUSE_BASE    = DEF_CAUSE_BASE
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             mem_err_int,
  input  logic                             me_i_en,
  input  logic [NUM_INTER-1:0]             interrupts,
  input  logic [NUM_INTER-1:0]             i_enable,
  input  logic                             p_int_read,
  input  logic                             csr_busy,
  output logic                             p_int,
  output logic [31:0]                      p_mcause,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count
);

  localparam int unsigned IDX_W = (NUM_INTER > 1) ? $clog2(NUM_INTER) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_INTER-1:0] w_req;
  logic [NUM_INTER-1:0] w_evt;
  logic [NUM_INTER-1:0] w_elig;
  logic [NUM_INTER-1:0] w_clr;
  logic [NUM_INTER-1:0] r_req_prev;
  logic [NUM_INTER-1:0] r_pend;
  logic                 w_req_me;
  logic                 w_evt_me;
  logic                 w_elig_me;
  logic                 w_clr_me;
  logic                 r_req_prev_me;
  logic                 r_pend_me;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     w_win;
  logic                 w_win_vld;
  logic                 w_rr_adv;
  logic                 w_space;
  logic                 w_push;
  logic [31:0]          w_push_data;
  logic                 w_pop;
  logic [31:0]          w_head;
  logic [CNT_W-1:0]     w_count;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_p_int;
  logic                 w_p_int_nxt;
  logic [31:0]          r_mcause;
  logic [31:0]          w_mcause_nxt;

  assign w_req     = interrupts & i_enable;
  assign w_req_me  = mem_err_int & me_i_en;
  assign w_evt     = w_req & ~r_req_prev;
  assign w_evt_me  = w_req_me & ~r_req_prev_me;
  assign w_elig    = r_pend | w_evt;
  assign w_elig_me = r_pend_me | w_evt_me;
  // Registered occupancy only: a pop this cycle does not make room.
  assign w_space   = (w_count < CNT_W'(QUEUE_DEPTH));

  // Pick a peripheral winner: lowest index, or rotating search from r_rr_ptr.
  always_comb begin : p_arb
    int unsigned v_idx;
    w_win     = '0;
    w_win_vld = 1'b0;
    v_idx     = 0;
    if (ARB_MODE == 1) begin
      for (int unsigned i = 0; i < NUM_INTER; i++) begin
        if (!w_win_vld && w_elig[i]) begin
          w_win     = IDX_W'(i);
          w_win_vld = 1'b1;
        end
      end
    end else begin
      for (int unsigned off = 0; off < NUM_INTER; off++) begin
        v_idx = {{(32-IDX_W){1'b0}}, r_rr_ptr} + off;
        if (v_idx >= NUM_INTER) begin
          v_idx = v_idx - NUM_INTER;
        end
        if (!w_win_vld && w_elig[IDX_W'(v_idx)]) begin
          w_win     = IDX_W'(v_idx);
          w_win_vld = 1'b1;
        end
      end
    end
  end

  // Enqueue at most one cause per cycle; the memory error always goes first.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_clr       = '0;
    w_clr_me    = 1'b0;
    w_rr_adv    = 1'b0;
    if (w_space) begin
      if (w_elig_me) begin
        w_push      = 1'b1;
        w_push_data = MEM_ERR_CAUSE;
        w_clr_me    = 1'b1;
      end else if (w_win_vld) begin
        w_push       = 1'b1;
        w_push_data  = CAUSE_BASE + {{(32-IDX_W){1'b0}}, w_win};
        w_clr[w_win] = 1'b1;
        w_rr_adv     = (ARB_MODE == 0);
      end
    end
  end

  // Edge history, sticky pending bits and round-robin pointer.
  // A new edge is kept pending unless it was itself the entry just enqueued
  // through the bypass; if an older pending copy was enqueued instead, the
  // new edge survives (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_prev    <= '0;
      r_req_prev_me <= 1'b0;
      r_pend        <= '0;
      r_pend_me     <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_req_prev    <= w_req;
      r_req_prev_me <= w_req_me;
      r_pend        <= (r_pend & ~w_clr) | (w_evt & ~(w_clr & ~r_pend));
      r_pend_me     <= (r_pend_me & ~w_clr_me) | (w_evt_me & ~(w_clr_me & ~r_pend_me));
      if (w_rr_adv) begin
        r_rr_ptr <= (w_win == IDX_W'(NUM_INTER - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  peripheral_int_fifo #(
    .WIDTH (32),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Handshake state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_p_int  <= 1'b0;
      r_mcause <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_p_int  <= w_p_int_nxt;
      r_mcause <= w_mcause_nxt;
    end
  end

  // Present the head when the CSR is free; pop only on acknowledge.
  always_comb begin
    w_state_nxt  = r_state;
    w_p_int_nxt  = r_p_int;
    w_mcause_nxt = r_mcause;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_p_int_nxt = 1'b0;
        if ((w_count != '0) && !csr_busy) begin
          w_p_int_nxt  = 1'b1;
          w_mcause_nxt = w_head;
          w_state_nxt  = SEND;
        end
      end
      SEND: begin
        if (p_int_read) begin
          w_pop       = 1'b1;
          w_p_int_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else if (csr_busy) begin
          w_p_int_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_p_int_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign p_int    = r_p_int;
  assign p_mcause = r_mcause;
  assign q_count  = w_count;

endmodule

// File: tb/tb_peripheral_interrupt_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share stimulus.
module tb_peripheral_interrupt_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_err_int;
  logic        me_i_en;
  logic [7:0]  interrupts;
  logic [7:0]  i_enable;
  logic        csr_busy;
  logic        rd0;
  logic        rd1;
  logic        p_int0;
  logic        p_int1;
  logic [31:0] mc0;
  logic [31:0] mc1;
  logic [2:0]  qc0;
  logic [2:0]  qc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_interrupt_arbiter #(
    .NUM_INTER   (8),
    .QUEUE_DEPTH (4),
    .ARB_MODE    (0)
  ) u_dut_rr (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_err_int (mem_err_int),
    .me_i_en     (me_i_en),
    .interrupts  (interrupts),
    .i_enable    (i_enable),
    .p_int_read  (rd0),
    .csr_busy    (csr_busy),
    .p_int       (p_int0),
    .p_mcause    (mc0),
    .q_count     (qc0)
  );

  peripheral_interrupt_arbiter #(
    .NUM_INTER   (8),
    .QUEUE_DEPTH (4),
    .ARB_MODE    (1)
  ) u_dut_fp (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_err_int (mem_err_int),
    .me_i_en     (me_i_en),
    .interrupts  (interrupts),
    .i_enable    (i_enable),
    .p_int_read  (rd1),
    .csr_busy    (csr_busy),
    .p_int       (p_int1),
    .p_mcause    (mc1),
    .q_count     (qc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    mem_err_int = 1'b0;
    me_i_en     = 1'b1;
    interrupts  = '0;
    i_enable    = '1;
    csr_busy    = 1'b0;
    rd0         = 1'b0;
    rd1         = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for p_int on instance sel, check the cause, acknowledge.
  task automatic ack(input int sel, input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (((sel == 0) ? p_int0 : p_int1) !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk($sformatf("%s_vld", tag), (sel == 0) ? p_int0 : p_int1, 1);
    chk($sformatf("%s_cause", tag), (sel == 0) ? mc0 : mc1, exp);
    if (sel == 0) rd0 = 1'b1;
    else          rd1 = 1'b1;
    tick();
    rd0 = 1'b0;
    rd1 = 1'b0;
    chk($sformatf("%s_drop", tag), (sel == 0) ? p_int0 : p_int1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n;

    // Reset state
    do_reset();
    chk("rst_pint", p_int0, 0);
    chk("rst_cause", mc0, 0);
    chk("rst_count", qc0, 0);

    // Single event, 2-cycle latency, held level enqueues once
    interrupts = 8'h08;
    tick();
    chk("single_q1", qc0, 1);
    chk("single_nopint", p_int0, 0);
    tick();
    chk("single_pint", p_int0, 1);
    chk("single_cause", mc0, 16);
    ack(0, "single_ack", 16);
    chk("single_q0", qc0, 0);
    repeat (3) tick();
    chk("hold_q0", qc0, 0);
    chk("hold_pint", p_int0, 0);
    interrupts = '0;

    // Memory error plus sources 0 and 5 together
    do_reset();
    mem_err_int = 1'b1;
    interrupts  = 8'h21;
    tick();
    ack(0, "sim_a", 12);
    ack(0, "sim_b", 13);
    ack(0, "sim_c", 18);
    mem_err_int = 1'b0;
    interrupts  = '0;

    // Source 3 first moves the rotating pointer; then 2 and 5 together
    do_reset();
    interrupts = 8'h08;
    tick();
    interrupts = '0;
    tick();
    interrupts = 8'h24;
    tick();
    interrupts = '0;
    ack(0, "rr_a", 16);
    ack(0, "rr_b", 18);
    ack(0, "rr_c", 15);
    ack(1, "fp_a", 16);
    ack(1, "fp_b", 15);
    ack(1, "fp_c", 18);

    // Sources 1 and 2 re-pulse every 4 cycles: they alternate
    do_reset();
    for (int r = 0; r < 2; r++) begin
      interrupts = 8'h06;
      tick();
      interrupts = '0;
      repeat (3) tick();
    end
    chk("fair_q4", qc0, 4);
    ack(0, "fair_a", 14);
    ack(0, "fair_b", 15);
    ack(0, "fair_c", 14);
    ack(0, "fair_d", 15);

    // Six events into a 4-deep queue, two stay pending
    do_reset();
    for (int i = 0; i < 6; i++) begin
      interrupts = 8'(1 << i);
      tick();
    end
    interrupts = '0;
    tick();
    chk("full_q4", qc0, 4);
    chk("full_pint", p_int0, 1);
    chk("full_head", mc0, 13);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    chk("full_pop_q3", qc0, 3);
    tick();
    chk("full_refill_q4", qc0, 4);
    ack(0, "full_b", 14);
    ack(0, "full_c", 15);
    ack(0, "full_d", 16);
    ack(0, "full_e", 17);
    ack(0, "full_f", 18);
    chk("full_empty", qc0, 0);

    // csr_busy abort and re-presentation
    do_reset();
    interrupts = 8'h08;
    tick();
    interrupts = '0;
    n = 0;
    while (p_int0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("busy_pint", p_int0, 1);
    chk("busy_cause", mc0, 16);
    csr_busy = 1'b1;
    tick();
    chk("busy_abort", p_int0, 0);
    chk("busy_kept", qc0, 1);
    tick();
    chk("busy_hold", p_int0, 0);
    csr_busy = 1'b0;
    ack(0, "busy_re", 16);
    chk("busy_q0", qc0, 0);

    // Disabled memory error is ignored; disabling a source keeps its entry
    do_reset();
    me_i_en     = 1'b0;
    mem_err_int = 1'b1;
    repeat (3) tick();
    chk("me_dis_q0", qc0, 0);
    mem_err_int = 1'b0;
    interrupts  = 8'h80;
    tick();
    i_enable   = '0;
    interrupts = '0;
    ack(0, "dis_keep", 20);

    // Asynchronous reset in the middle of a presentation
    do_reset();
    interrupts = 8'h50;
    n = 0;
    while (p_int0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("arst_pre", mc0, 17);
    #2;
    reset_n    = 1'b0;
    interrupts = '0;
    #1;
    chk("arst_pint", p_int0, 0);
    chk("arst_cause", mc0, 0);
    chk("arst_count", qc0, 0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (p_int0 !== 1'b0) seen = 1'b1;
    end
    chk("arst_none", seen, 0);
    chk("arst_q0", qc0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
